// File: rtl/edge_event_scheduler_if.sv
// Event delivery handshake between the edge scheduler (master) and its consumer (slave).
interface edge_event_scheduler_if #(
   parameter int unsigned N = 4
);
   localparam int unsigned ChW = $clog2(N);

   logic           evt_valid;
   logic           evt_ready;
   logic [ChW-1:0] evt_chan;
   logic           evt_kind;

   modport master (
      output evt_valid,
      output evt_chan,
      output evt_kind,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_chan,
      input  evt_kind,
      output evt_ready
   );
endinterface

// File: rtl/edge_event_scheduler.sv
// Detects enabled rise/fall edges on N channels, queues one event per channel and
// delivers them round-robin through a registered valid/ready output slot.
module edge_event_scheduler #(
   parameter int unsigned N  = 4,
   parameter int unsigned CW = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N-1:0]           sig_in,
   input  logic [N-1:0]           cfg_rise_en,
   input  logic [N-1:0]           cfg_fall_en,
   output logic [N-1:0]           ovf,
   input  logic [N-1:0]           ovf_clr,
   input  logic                   cnt_clr,
   output logic [CW-1:0]          evt_count,
   edge_event_scheduler_if.master evt_if
);
   localparam int unsigned ChW = $clog2(N);

   logic [N-1:0]   prev_q, prev_d;
   logic           primed_q, primed_d;
   logic [N-1:0]   pend_q, pend_d;
   logic [N-1:0]   pkind_q, pkind_d;
   logic [N-1:0]   ovf_q, ovf_d;
   logic           valid_q, valid_d;
   logic [ChW-1:0] chan_q, chan_d;
   logic           kind_q, kind_d;
   logic [ChW-1:0] rr_q, rr_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   logic [N-1:0]   rise, fall, new_ovf;
   logic           grant_vld, load, take, hs;
   logic [ChW-1:0] grant_idx;
   int             cand;

   // Edges are suppressed until prev holds a real sample after reset.
   assign rise = primed_q ? (sig_in & ~prev_q & cfg_rise_en) : '0;
   assign fall = primed_q ? (~sig_in & prev_q & cfg_fall_en) : '0;

   assign load = !valid_q || evt_if.evt_ready;
   assign take = load && grant_vld;
   assign hs   = valid_q && evt_if.evt_ready;

   // Round-robin search beginning one past the last granted channel.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = 0;
      for (int i = 1; i <= int'(N); i++) begin
         cand = (int'(rr_q) + i) % int'(N);
         if (!grant_vld && pend_q[cand]) begin
            grant_vld = 1'b1;
            grant_idx = ChW'(cand);
         end
      end
   end

   always_comb begin
      prev_d   = sig_in;
      primed_d = 1'b1;
      pend_d   = pend_q;
      pkind_d  = pkind_q;
      new_ovf  = '0;
      valid_d  = valid_q;
      chan_d   = chan_q;
      kind_d   = kind_q;
      rr_d     = rr_q;
      cnt_d    = cnt_q;

      if (take) begin
         pend_d[grant_idx] = 1'b0;
      end

      // A slot freed this cycle accepts the new edge; a slot still occupied keeps the older one.
      for (int c = 0; c < int'(N); c++) begin
         if (rise[c] || fall[c]) begin
            if (pend_d[c]) begin
               new_ovf[c] = 1'b1;
            end else begin
               pend_d[c]  = 1'b1;
               pkind_d[c] = rise[c];
            end
         end
      end

      ovf_d = (ovf_q & ~ovf_clr) | new_ovf;

      if (load) begin
         valid_d = grant_vld;
         if (grant_vld) begin
            chan_d = grant_idx;
            kind_d = pkind_q[grant_idx];
            rr_d   = grant_idx;
         end
      end

      if (cnt_clr) begin
         cnt_d = '0;
      end else if (hs && (cnt_q != '1)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q   <= '0;
         primed_q <= 1'b0;
         pend_q   <= '0;
         pkind_q  <= '0;
         ovf_q    <= '0;
         valid_q  <= 1'b0;
         chan_q   <= '0;
         kind_q   <= 1'b0;
         rr_q     <= ChW'(N - 1);
         cnt_q    <= '0;
      end else begin
         prev_q   <= prev_d;
         primed_q <= primed_d;
         pend_q   <= pend_d;
         pkind_q  <= pkind_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
         chan_q   <= chan_d;
         kind_q   <= kind_d;
         rr_q     <= rr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign evt_if.evt_valid = valid_q;
   assign evt_if.evt_chan  = chan_q;
   assign evt_if.evt_kind  = kind_q;
   assign ovf              = ovf_q;
   assign evt_count        = cnt_q;
endmodule

// File: tb/tb_edge_event_scheduler.sv
// Scoreboard bench for edge_event_scheduler: expected events are queued as edges are driven
// and matched against every handshake on the event port.
module tb_edge_event_scheduler;
   localparam int unsigned N  = 4;
   localparam int unsigned CW = 4;

   typedef struct packed {
      logic [1:0] chan;
      logic       kind;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  sig_in;
   logic [N-1:0]  cfg_rise_en;
   logic [N-1:0]  cfg_fall_en;
   logic [N-1:0]  ovf;
   logic [N-1:0]  ovf_clr;
   logic          cnt_clr;
   logic [CW-1:0] evt_count;

   edge_event_scheduler_if #(.N(N)) evt_if ();

   edge_event_scheduler #(.N(N), .CW(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .sig_in      (sig_in),
      .cfg_rise_en (cfg_rise_en),
      .cfg_fall_en (cfg_fall_en),
      .ovf         (ovf),
      .ovf_clr     (ovf_clr),
      .cnt_clr     (cnt_clr),
      .evt_count   (evt_count),
      .evt_if      (evt_if)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic push(input int c, input logic k);
      exp_t e;
      e.chan = c[1:0];
      e.kind = k;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input int max_cyc);
      for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) step();
      check_eq("drain", exp_q.size(), 0);
   endtask

   // Inputs are stable at negedge, so valid&ready here is the handshake of the next posedge.
   always @(negedge clk) begin
      if (!rst && evt_if.evt_valid && evt_if.evt_ready) begin
         check_eq("evt_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check_eq("evt_chan", evt_if.evt_chan, mon_e.chan);
            check_eq("evt_kind", evt_if.evt_kind, mon_e.kind);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; sig_in = '0; cfg_rise_en = '0; cfg_fall_en = '0;
      ovf_clr = '0; cnt_clr = 1'b0; evt_if.evt_ready = 1'b0;
      step(); step();
      check_eq("rst_valid", evt_if.evt_valid, 0);
      check_eq("rst_chan", evt_if.evt_chan, 0);
      check_eq("rst_kind", evt_if.evt_kind, 0);
      check_eq("rst_ovf", ovf, 0);
      check_eq("rst_count", evt_count, 0);

      // Single rise and minimum latency
      cfg_rise_en = 4'hF; evt_if.evt_ready = 1'b1; rst = 1'b0;
      step();
      sig_in[2] = 1'b1; push(2, 1'b1);
      step();
      check_eq("lat_k_valid", evt_if.evt_valid, 0);
      step();
      check_eq("lat_k1_valid", evt_if.evt_valid, 1);
      check_eq("lat_k1_chan", evt_if.evt_chan, 2);
      check_eq("lat_k1_kind", evt_if.evt_kind, 1);
      step();
      check_eq("single_count", evt_count, 1);
      check_eq("single_idle", evt_if.evt_valid, 0);
      sig_in = '0; step();

      // Round-robin burst from reset pointer, then after wrap
      rst = 1'b1; step(); rst = 1'b0; step();
      sig_in = 4'b1011; push(0, 1'b1); push(1, 1'b1); push(3, 1'b1);
      step();
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("burst_nobubble", evt_if.evt_valid, 1);
      end
      step();
      check_eq("burst_end", evt_if.evt_valid, 0);
      sig_in = '0; step();
      sig_in = 4'b0011; push(0, 1'b1); push(1, 1'b1);
      wait_drain(10);

      // Backpressure, replace-on-take, overflow with coincident clear
      sig_in = '0; step();
      evt_if.evt_ready = 1'b0; cfg_fall_en = 4'hF; step();
      sig_in = 4'b0010; push(1, 1'b1); push(1, 1'b0);
      step();
      check_eq("bp_valid0", evt_if.evt_valid, 0);
      sig_in = 4'b0000; step();
      check_eq("bp_valid1", evt_if.evt_valid, 1);
      check_eq("bp_chan", evt_if.evt_chan, 1);
      check_eq("bp_kind", evt_if.evt_kind, 1);
      check_eq("bp_no_ovf", ovf, 0);
      sig_in = 4'b0010; ovf_clr = 4'b0010; step(); ovf_clr = '0;
      check_eq("ovf_set_wins", ovf, 4'b0010);
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("hold_valid", evt_if.evt_valid, 1);
         check_eq("hold_chan", evt_if.evt_chan, 1);
         check_eq("hold_kind", evt_if.evt_kind, 1);
      end
      evt_if.evt_ready = 1'b1;
      wait_drain(10);
      step(); step();
      check_eq("bp_dropped", evt_if.evt_valid, 0);
      ovf_clr = 4'b0010; step(); ovf_clr = '0;
      check_eq("ovf_clr", ovf, 0);

      // Priming: high inputs across reset release give no events
      sig_in = 4'hF; rst = 1'b1; step(); step(); rst = 1'b0;
      step(); step(); step();
      check_eq("prime_valid", evt_if.evt_valid, 0);
      check_eq("prime_count", evt_count, 0);
      sig_in = '0;
      for (int c = 0; c < 4; c++) push(c, 1'b0);
      wait_drain(12);
      check_eq("fall_count", evt_count, 4);

      // Saturating counter and clear-wins
      cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
      check_eq("cnt_cleared", evt_count, 0);
      for (int i = 0; i < 16; i++) begin
         sig_in[0] = ~sig_in[0]; push(0, sig_in[0]);
         step();
      end
      wait_drain(10);
      check_eq("cnt_sat", evt_count, 15);
      check_eq("stream_no_ovf", ovf, 0);
      sig_in[0] = ~sig_in[0]; push(0, sig_in[0]);
      step(); step();
      check_eq("clr_hs_valid", evt_if.evt_valid, 1);
      cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
      check_eq("cnt_clr_wins", evt_count, 0);

      // Reset mid-burst discards everything
      cfg_rise_en = '0; cfg_fall_en = '0; evt_if.evt_ready = 1'b0; sig_in = '0;
      step(); step();
      cfg_rise_en = 4'hF; cfg_fall_en = 4'hF; sig_in = 4'b0111; step();
      sig_in = '0; step();
      check_eq("mid_valid", evt_if.evt_valid, 1);
      check_eq("mid_chan", evt_if.evt_chan, 1);
      check_eq("mid_ovf", ovf, 4'b0101);
      evt_if.evt_ready = 1'b1; push(1, 1'b1); step(); evt_if.evt_ready = 1'b0;
      check_eq("mid_count", evt_count, 1);
      check_eq("mid_next_chan", evt_if.evt_chan, 2);
      check_eq("mid_next_kind", evt_if.evt_kind, 1);
      sig_in = 4'b1000; rst = 1'b1; step(); rst = 1'b0;
      check_eq("mrst_valid", evt_if.evt_valid, 0);
      check_eq("mrst_chan", evt_if.evt_chan, 0);
      check_eq("mrst_kind", evt_if.evt_kind, 0);
      check_eq("mrst_ovf", ovf, 0);
      check_eq("mrst_count", evt_count, 0);
      evt_if.evt_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq("mrst_quiet", evt_if.evt_valid, 0);
      end
      check_eq("final_queue", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/edge_event_scheduler.md
EDGE_EVENT_SCHEDULER -- requirements
Module: edge_event_scheduler

Interface
REQ-001 Parameter: N, 4, number of monitored input channels (2..8).
REQ-002 Parameter: CW, 16, width of the delivered-event counter.
REQ-003 Port: clk  input  1  single clock; all logic samples on posedge clk.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: sig_in  input  N  monitored signals, synchronous to clk, no synchronizer inside.
REQ-006 Port: cfg_rise_en  input  N  per-channel enable for rising-edge events.
REQ-007 Port: cfg_fall_en  input  N  per-channel enable for falling-edge events.
REQ-008 Port: evt_valid  output  1  event present on evt_chan/evt_kind.
REQ-009 Port: evt_ready  input  1  consumer accepts event when evt_valid=1.
REQ-010 Port: evt_chan  output  clog2(N)  channel index of presented event.
REQ-011 Port: evt_kind  output  1  1=rise, 0=fall.
REQ-012 Port: ovf  output  N  sticky per-channel overflow flags.
REQ-013 Port: ovf_clr  input  N  per-channel overflow clear strobe.
REQ-014 Port: cnt_clr  input  1  clears evt_count.
REQ-015 Port: evt_count  output  CW  saturating count of accepted events.

Function
REQ-016 Block SHALL register sig_in each cycle as prev; rise on ch = sig_in[ch]&~prev[ch]&cfg_rise_en[ch]; fall = ~sig_in[ch]&prev[ch]&cfg_fall_en[ch].
REQ-017 First posedge after rst deasserts SHALL only load prev (primed flag set), generating no events regardless of sig_in level.
REQ-018 Each channel SHALL hold a one-deep pending slot (pend flag + kind); a detected edge at posedge k sets the slot at posedge k.
REQ-019 Output stage SHALL be a registered slot: loads when evt_valid=0 or (evt_valid & evt_ready), taking one pending channel chosen by the arbiter.
REQ-020 Arbiter SHALL be round-robin: search starts at last-granted+1 mod N; pointer updates only on a load.
REQ-021 Minimum latency: edge sampled at posedge k -> evt_valid=1 after posedge k+1 (empty pipeline).
REQ-022 While evt_valid=1 and evt_ready=0, evt_valid, evt_chan, evt_kind SHALL hold stable.
REQ-023 With continuous evt_ready=1 and pending work, one event SHALL be delivered per cycle (no bubbles).
REQ-024 Edge on channel whose slot is being loaded to output in the same cycle: slot SHALL take the new edge, no overflow.
REQ-025 Edge on channel whose slot stays pending: the older event SHALL be kept, new one dropped, ovf[ch] set.
REQ-026 ovf_clr[ch] coincident with a new overflow on ch: set wins, ovf[ch]=1.
REQ-027 evt_count SHALL increment on each evt_valid & evt_ready, saturating at 2^CW-1.
REQ-028 cnt_clr coincident with a handshake: clear wins, evt_count=0.
REQ-029 Deasserting cfg_*_en SHALL not flush already-pending events.

Reset
REQ-030 With rst=1 at posedge: evt_valid=0, evt_chan=0, evt_kind=0, ovf=0, evt_count=0, all pend=0, prev=0, primed=0, RR pointer=N-1 (channel 0 first).
REQ-031 rst asserted mid-operation SHALL discard pending and presented events within that same posedge; no event delivered for the edge sampled in the reset cycle.

Verification
REQ-032 Single rise: rise_en=1111, evt_ready=1, sig_in[2] 0->1 at posedge 5 -> evt_valid=1, evt_chan=2, evt_kind=1 after posedge 6, count=1.
REQ-033 Simultaneous rises on ch 0,1,3 with evt_ready=1 -> delivered chan 0,1,3 on three consecutive cycles; next burst on 0,1 -> order 0,1 after pointer wraps.
REQ-034 Backpressure: evt_ready=0, ch1 pulses 1-0 over two cycles -> rise presented and held, fall pending, second rise sets ovf[1]=1; after ready=1 deliver rise then fall only.
REQ-035 Post-reset priming: sig_in=1111 held through rst release -> no events; cfg_fall_en=1111, sig_in->0000 -> four fall events delivered.
REQ-036 Counter: CW=4, 16 accepted events -> evt_count=15; cnt_clr with handshake in same cycle -> 0.
REQ-037 Reset mid-burst: rst=1 while evt_valid=1 and 2 pending -> next cycle evt_valid=0, pend=0, ovf=0, count=0.
